bsg_link_channel_striper: RTL and testbench

- Core-side successor to the single-channel DDR uplink front end.
- Stripes a core flit stream across num_channels_p independent link channels and stamps each flit with a wrapping sequence number so the receiver can reorder.
- Channel choice is round-robin over enabled channels that have credits.
- Each channel has its own credit counter replenished by token pulses and a one-entry output register.
- Sits between core logic and num_channels_p bsg_link_ddr_upstream instances, all in core_clk_i.

---
 rtl/bsg_link_striper_pkg.sv | 13 +
 rtl/bsg_link_striper_channel.sv | 72 +++++++
 rtl/bsg_link_channel_striper.sv | 107 ++++++++++
 tb/tb_bsg_link_channel_striper.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_striper_pkg.sv
// Shared types and constants for the link channel striper.
// The flit struct is a macro because its field widths come from module parameters.
`define BSG_LINK_STRIPER_FLIT_T(seq_w, pay_w) \
   struct packed { logic [(seq_w)-1:0] seq; logic [(pay_w)-1:0] payload; }

package bsg_link_striper_pkg;

   // Full credit count for a downstream FIFO of 2**lg_depth entries.
   function automatic int credits_max(input int lg_depth);
      return 1 << lg_depth;
   endfunction

endpackage

// File: rtl/bsg_link_striper_channel.sv
// One link channel: credit counter, one-entry output register and eligibility.
module bsg_link_striper_channel
   import bsg_link_striper_pkg::*;
#(
   parameter int width_p                         = 64,
   parameter int seq_width_p                     = 8,
   parameter int lg_fifo_depth_p                 = 3,
   parameter int lg_credit_to_token_decimation_p = 0
)(
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           en_i,
   input  logic                           token_i,
   input  logic                           out_ready_and_i,
   input  logic                           load_i,
   input  logic [seq_width_p-1:0]         seq_i,
   input  logic [width_p-1:0]             data_i,
   output logic                           eligible_o,
   output logic [seq_width_p+width_p-1:0] out_data_o,
   output logic                           out_v_o,
   output logic                           idle_d_o,
   output logic                           overflow_o
);

   typedef `BSG_LINK_STRIPER_FLIT_T(seq_width_p, width_p) flit_t;

   localparam int cnt_w = lg_fifo_depth_p + 1;
   // Wide enough that credit + token increment can never wrap before the saturation test.
   localparam int sum_w = lg_fifo_depth_p + lg_credit_to_token_decimation_p + 3;
   localparam logic [cnt_w-1:0] max_cnt   = cnt_w'(credits_max(lg_fifo_depth_p));
   localparam logic [sum_w-1:0] max_sum   = sum_w'(credits_max(lg_fifo_depth_p));
   localparam logic [sum_w-1:0] token_inc = sum_w'(credits_max(lg_credit_to_token_decimation_p));

   logic [cnt_w-1:0] credit_q, credit_d;
   logic             v_q, v_d;
   flit_t            flit_q, flit_d;
   logic [sum_w-1:0] credit_sum;

   // A channel can take a flit if enabled, it has a credit, and its register is free or draining.
   assign eligible_o = en_i & (credit_q != '0) & (~v_q | out_ready_and_i);
   assign out_data_o = flit_q;
   assign out_v_o    = v_q;

   // Next-state: net credit change with saturation, register drain/reload.
   always_comb begin
      credit_sum = sum_w'(credit_q) + (token_i ? token_inc : '0) - sum_w'(load_i);
      overflow_o = (credit_sum > max_sum);
      credit_d   = overflow_o ? max_cnt : credit_sum[cnt_w-1:0];
      v_d        = v_q & ~out_ready_and_i;
      flit_d     = flit_q;
      if (load_i) begin
         v_d            = 1'b1;
         flit_d.seq     = seq_i;
         flit_d.payload = data_i;
      end
      idle_d_o = ~v_d & (credit_d == max_cnt);
   end

   // Channel state registers; reset restores full credit and drops any pending flit.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         credit_q <= max_cnt;
         v_q      <= 1'b0;
         flit_q   <= '0;
      end else begin
         credit_q <= credit_d;
         v_q      <= v_d;
         flit_q   <= flit_d;
      end
   end

endmodule

// File: rtl/bsg_link_channel_striper.sv
// Stripes a core flit stream round-robin over link channels, tagging each flit
// with a wrapping sequence number so the far side can restore order.
module bsg_link_channel_striper
   import bsg_link_striper_pkg::*;
#(
   parameter int width_p                         = 64,
   parameter int num_channels_p                  = 4,
   parameter int lg_fifo_depth_p                 = 3,
   parameter int lg_credit_to_token_decimation_p = 0,
   parameter int seq_width_p                     = 8
)(
   input  logic                                              core_clk_i,
   input  logic                                              core_reset_n_i,
   input  logic [num_channels_p-1:0]                         channel_en_i,
   input  logic [width_p-1:0]                                data_i,
   input  logic                                              v_i,
   output logic                                              ready_and_o,
   output logic [num_channels_p*(seq_width_p+width_p)-1:0]   out_data_o,
   output logic [num_channels_p-1:0]                         out_v_o,
   input  logic [num_channels_p-1:0]                         out_ready_and_i,
   input  logic [num_channels_p-1:0]                         token_i,
   output logic                                              idle_o,
   output logic                                              credit_overflow_o
);

   localparam int flit_w = seq_width_p + width_p;
   localparam int ptr_w  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
   localparam logic [ptr_w:0] n_ch = (ptr_w+1)'(num_channels_p);

   logic [num_channels_p-1:0]   eligible, load, ch_idle_d, ch_ovf;
   logic [2*num_channels_p-1:0] elig_dbl;
   logic [num_channels_p-1:0]   elig_rot;
   logic [ptr_w-1:0]            rot_idx, sel;
   logic [ptr_w:0]              sel_sum, nxt_sum;
   logic [ptr_w-1:0]            rr_ptr_q, rr_ptr_d;
   logic [seq_width_p-1:0]      seq_q, seq_d;
   logic                        idle_q, idle_d, ovf_q, ovf_d, accept;

   assign ready_and_o       = |eligible;
   assign accept            = v_i & ready_and_o;
   assign idle_o            = idle_q;
   assign credit_overflow_o = ovf_q;

   // Round-robin pick: rotate so rr_ptr is bit 0, take the lowest set bit, rotate back.
   always_comb begin
      elig_dbl = {eligible, eligible} >> rr_ptr_q;
      elig_rot = elig_dbl[num_channels_p-1:0];
      rot_idx  = '0;
      for (int i = num_channels_p-1; i >= 0; i--) begin
         if (elig_rot[i]) rot_idx = ptr_w'(i);
      end
      sel_sum = {1'b0, rr_ptr_q} + {1'b0, rot_idx};
      if (sel_sum >= n_ch) sel_sum = sel_sum - n_ch;
      sel = sel_sum[ptr_w-1:0];
   end

   // Dispatch decode and pointer/sequence/status next-state.
   always_comb begin
      load = '0;
      if (accept) load[sel] = 1'b1;
      nxt_sum = {1'b0, sel} + 1'b1;
      if (nxt_sum >= n_ch) nxt_sum = '0;
      rr_ptr_d = accept ? nxt_sum[ptr_w-1:0] : rr_ptr_q;
      seq_d    = accept ? seq_q + 1'b1 : seq_q;
      idle_d   = &ch_idle_d;
      ovf_d    = ovf_q | (|ch_ovf);
   end

   // Top-level registers; overflow is sticky until reset.
   always_ff @(posedge core_clk_i) begin
      if (!core_reset_n_i) begin
         rr_ptr_q <= '0;
         seq_q    <= '0;
         idle_q   <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         seq_q    <= seq_d;
         idle_q   <= idle_d;
         ovf_q    <= ovf_d;
      end
   end

   for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
      bsg_link_striper_channel #(
         .width_p                         (width_p),
         .seq_width_p                     (seq_width_p),
         .lg_fifo_depth_p                 (lg_fifo_depth_p),
         .lg_credit_to_token_decimation_p (lg_credit_to_token_decimation_p)
      ) u_ch (
         .clk_i           (core_clk_i),
         .reset_n_i       (core_reset_n_i),
         .en_i            (channel_en_i[c]),
         .token_i         (token_i[c]),
         .out_ready_and_i (out_ready_and_i[c]),
         .load_i          (load[c]),
         .seq_i           (seq_q),
         .data_i          (data_i),
         .eligible_o      (eligible[c]),
         .out_data_o      (out_data_o[c*flit_w +: flit_w]),
         .out_v_o         (out_v_o[c]),
         .idle_d_o        (ch_idle_d[c]),
         .overflow_o      (ch_ovf[c])
      );
   end

endmodule

// File: tb/tb_bsg_link_channel_striper.sv
// Directed bench for the link channel striper (4 channels, 8 credits, 8-bit seq).
module tb_bsg_link_channel_striper;

   localparam int W  = 64;
   localparam int N  = 4;
   localparam int SW = 8;
   localparam int FW = SW + W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    en;
   logic [W-1:0]    data;
   logic            v;
   logic            ready;
   logic [N*FW-1:0] out_data;
   logic [N-1:0]    out_v;
   logic [N-1:0]    out_ready;
   logic [N-1:0]    token;
   logic            idle;
   logic            ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bsg_link_channel_striper #(
      .width_p(W), .num_channels_p(N), .lg_fifo_depth_p(3),
      .lg_credit_to_token_decimation_p(0), .seq_width_p(SW)
   ) dut (
      .core_clk_i        (clk),
      .core_reset_n_i    (rst_n),
      .channel_en_i      (en),
      .data_i            (data),
      .v_i               (v),
      .ready_and_o       (ready),
      .out_data_o        (out_data),
      .out_v_o           (out_v),
      .out_ready_and_i   (out_ready),
      .token_i           (token),
      .idle_o            (idle),
      .credit_overflow_o (ovf)
   );

   // Advance one clock; inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; en = '0; data = '0; v = 1'b0; out_ready = '0; token = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b1; en = '0; data = '0; v = 1'b0; out_ready = '0; token = '0;
      step();
      apply_reset();
      #1;
      n_checks++; if (out_v !== 4'b0) begin n_fail++; $display("FAIL reset_out_v got=%b exp=0000", out_v); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_disabled got=%b exp=0", ready); end
      en = 4'hF;
      #1;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_enabled got=%b exp=1", ready); end
   endtask

   task automatic test_round_robin();
      logic [FW-1:0] got, exp;
      int ch;
      en = 4'hF; out_ready = 4'hF; v = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data = 64'hA0 + 64'(i);
         #1;
         n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready i=%0d got=%b exp=1", i, ready); end
         step();
         ch  = i % N;
         got = out_data[ch*FW +: FW];
         exp = {8'(i), 64'hA0 + 64'(i)};
         n_checks++; if (out_v !== (4'b1 << ch)) begin n_fail++; $display("FAIL rr_out_v i=%0d got=%b exp=%b", i, out_v, 4'b1 << ch); end
         n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rr_data i=%0d ch=%0d got=%h exp=%h", i, ch, got, exp); end
      end
      v = 1'b0;
      step();
      n_checks++; if (out_v !== 4'b0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0000", out_v); end
      n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rr_not_idle got=%b exp=0", idle); end
      token = 4'hF;
      step();
      step();
      token = '0;
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rr_idle_after_tokens got=%b exp=1", idle); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rr_no_ovf got=%b exp=0", ovf); end
   endtask

   task automatic test_credit_exhaust();
      int cnt;
      logic [FW-1:0] got;
      apply_reset();
      en = 4'b0001; out_ready = 4'hF; v = 1'b1; data = 64'hC0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (ready) cnt++;
         step();
      end
      #1;
      n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL exhaust_count got=%0d exp=8", cnt); end
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_ready got=%b exp=0", ready); end
      v = 1'b0; token = 4'b0001;
      step();
      token = '0; v = 1'b1; data = 64'hC8;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (ready) cnt++;
         step();
      end
      v = 1'b0;
      got = out_data[0 +: FW];
      n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL exhaust_token_count got=%0d exp=1", cnt); end
      n_checks++; if (got !== {8'd8, 64'hC8}) begin n_fail++; $display("FAIL exhaust_token_data got=%h exp=%h", got, {8'd8, 64'hC8}); end
   endtask

   task automatic test_enable_mask();
      logic [FW-1:0] got, exp;
      int ch;
      apply_reset();
      en = 4'b1010; out_ready = 4'hF; v = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data = 64'hD0 + 64'(i);
         step();
         ch  = (i % 2 == 0) ? 1 : 3;
         got = out_data[ch*FW +: FW];
         exp = {8'(i), 64'hD0 + 64'(i)};
         n_checks++; if (out_v !== (4'b1 << ch)) begin n_fail++; $display("FAIL mask_out_v i=%0d got=%b exp=%b", i, out_v, 4'b1 << ch); end
         n_checks++; if (got !== exp) begin n_fail++; $display("FAIL mask_data i=%0d got=%h exp=%h", i, got, exp); end
      end
      en = 4'b0000;
      #1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mask_all_off_ready got=%b exp=0", ready); end
      v = 1'b0;
      step();
   endtask

   task automatic test_stall();
      logic [FW-1:0] got, exp;
      int exp_ch [7] = '{0, 1, 2, 3, 0, 1, 3};
      int ch;
      apply_reset();
      en = 4'hF; out_ready = 4'b1011; v = 1'b1;
      for (int i = 0; i < 7; i++) begin
         data = 64'hB0 + 64'(i);
         #1;
         n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready i=%0d got=%b exp=1", i, ready); end
         step();
         ch  = exp_ch[i];
         got = out_data[ch*FW +: FW];
         exp = {8'(i), 64'hB0 + 64'(i)};
         n_checks++; if (got !== exp || out_v[ch] !== 1'b1) begin n_fail++; $display("FAIL stall_data i=%0d ch=%0d got=%h v=%b exp=%h", i, ch, got, out_v[ch], exp); end
      end
      v = 1'b0;
      got = out_data[2*FW +: FW];
      n_checks++; if (got !== {8'd2, 64'hB2} || out_v[2] !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%h v=%b exp=%h", got, out_v[2], {8'd2, 64'hB2}); end
      out_ready = 4'hF;
      step();
      n_checks++; if (out_v !== 4'b0) begin n_fail++; $display("FAIL stall_release got=%b exp=0000", out_v); end
   endtask

   task automatic test_overflow();
      int cnt;
      apply_reset();
      token = 4'b0010;
      step();
      token = '0;
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ovf); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ovf_idle got=%b exp=1", idle); end
      en = 4'b0010; out_ready = 4'hF; v = 1'b1; data = 64'hE0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (ready) cnt++;
         step();
      end
      v = 1'b0;
      n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL ovf_credit_saturated got=%0d exp=8", cnt); end
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
      apply_reset();
      #1;
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ovf_reset_idle got=%b exp=1", idle); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_credit_exhaust();
      test_enable_mask();
      test_stall();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
